// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
package imem_arb_pkg;

  localparam int unsigned BURST_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOCKED  = 2'd1,
    RESTART = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_LOAD  = 2'd2
  } grant_sel_e;

endpackage

// File: rtl/imem_arb_grant.sv
// Combinational grant selection: picks at most one of fetch/load per cycle
// from the requests, the arbiter state and the load-burst counter.
module imem_arb_grant
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_LOAD_BURST = 4
) (
  input  logic                   fetch_req_i,
  input  logic                   load_req_i,
  input  logic                   lock_i,
  input  arb_state_e             state_i,
  input  logic [BURST_CNT_W-1:0] burst_count_i,
  output grant_sel_e             grant_o
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_LOAD_BURST);

  always_comb begin
    grant_o = GRANT_NONE;
    case (state_i)
      RUN: begin
        // A rising lock already keeps the core off the RAM in its first cycle.
        if (lock_i) begin
          if (load_req_i) grant_o = GRANT_LOAD;
        end else if (load_req_i && fetch_req_i) begin
          grant_o = (burst_count_i == BURST_LIMIT) ? GRANT_FETCH : GRANT_LOAD;
        end else if (load_req_i) begin
          grant_o = GRANT_LOAD;
        end else if (fetch_req_i) begin
          grant_o = GRANT_FETCH;
        end
      end
      LOCKED: begin
        if (load_req_i) grant_o = GRANT_LOAD;
      end
      RESTART: grant_o = GRANT_NONE;
      default: grant_o = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares one single-port synchronous instruction RAM between the core fetch port
// and the program loader. Optional perf counters are built when IMEM_ARB_PERF_EN is defined.
//
// Handshakes: a requester raises *_req_in with stable address/data and holds it
// until the matching fetch_ready_out / load_ack_out is seen high in a cycle; that
// cycle is the transfer. Fetch data follows as fetch_valid_out one cycle later.
module imem_access_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH     = 11,
  parameter int unsigned MAX_LOAD_BURST    = 4
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         fetch_req_in,
  input  logic [ADDRESS_WIDTH-1:0]     fetch_address_in,
  output logic                         fetch_ready_out,
  output logic                         fetch_valid_out,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instruction_out,
  input  logic                         load_req_in,
  input  logic [ADDRESS_WIDTH-1:0]     load_address_in,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data_in,
  output logic                         load_ack_out,
  input  logic                         load_lock_in,
  output logic                         cpu_restart_out,
  output logic [ADDRESS_WIDTH-1:0]     mem_address_out,
  output logic                         mem_write_out,
  output logic [INSTRUCTION_WIDTH-1:0] mem_data_out,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data_in,
  output arb_state_e                   arb_state_out
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]                  fetch_stall_count_out,
  output logic [31:0]                  load_write_count_out
`endif
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_LOAD_BURST);

  arb_state_e                   state_q, state_d;
  logic [BURST_CNT_W-1:0]       burst_q, burst_d;
  logic                         fetch_pend_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [ADDRESS_WIDTH-1:0]     addr_q;
  logic [INSTRUCTION_WIDTH-1:0] wdata_q;

  grant_sel_e grant;
  logic       grant_fetch;
  logic       grant_load;

  // Nothing is granted while reset is asserted, so no RAM write can slip through.
  imem_arb_grant #(
    .MAX_LOAD_BURST(MAX_LOAD_BURST)
  ) u_grant (
    .fetch_req_i  (fetch_req_in & ~reset_in),
    .load_req_i   (load_req_in & ~reset_in),
    .lock_i       (load_lock_in),
    .state_i      (state_q),
    .burst_count_i(burst_q),
    .grant_o      (grant)
  );

  assign grant_fetch = (grant == GRANT_FETCH);
  assign grant_load  = (grant == GRANT_LOAD);

  always_comb begin
    state_d         = state_q;
    cpu_restart_out = 1'b0;
    case (state_q)
      RUN: begin
        if (load_lock_in) state_d = LOCKED;
      end
      LOCKED: begin
        if (!load_lock_in) state_d = RESTART;
      end
      RESTART: begin
        cpu_restart_out = ~reset_in;
        state_d         = load_lock_in ? LOCKED : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (!fetch_req_in || grant_fetch) begin
      burst_d = '0;
    end else if (grant_load && (burst_q != BURST_LIMIT)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_comb begin
    fetch_ready_out = grant_fetch;
    load_ack_out    = grant_load;
    mem_write_out   = grant_load;
    mem_address_out = addr_q;
    mem_data_out    = wdata_q;
    if (grant_load) begin
      mem_address_out = load_address_in;
      mem_data_out    = load_data_in;
    end else if (grant_fetch) begin
      mem_address_out = fetch_address_in;
    end
  end

  // RAM data is live in the cycle after the grant; it is captured for holding.
  assign fetch_valid_out       = fetch_pend_q & ~reset_in;
  assign fetch_instruction_out = fetch_valid_out ? mem_data_in : instr_q;
  assign arb_state_out         = state_q;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= RUN;
      burst_q      <= '0;
      fetch_pend_q <= 1'b0;
      instr_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      fetch_pend_q <= grant_fetch;
      addr_q       <= mem_address_out;
      wdata_q      <= mem_data_out;
      if (fetch_valid_out) instr_q <= mem_data_in;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] load_cnt_q, load_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    load_cnt_d  = load_cnt_q;
    if (fetch_req_in && !grant_fetch && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (grant_load && (load_cnt_q != '1)) load_cnt_d = load_cnt_q + 32'd1;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      stall_cnt_q <= '0;
      load_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign fetch_stall_count_out = stall_cnt_q;
  assign load_write_count_out  = load_cnt_q;
`endif

endmodule
